// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file command sequencer:
// FunSel codes, opcodes, register indices and the sequencer state enum.
package regfile_pkg;

   localparam logic [2:0] FS_DEC  = 3'b000;
   localparam logic [2:0] FS_INC  = 3'b001;
   localparam logic [2:0] FS_LOAD = 3'b010;
   localparam logic [2:0] FS_CLR  = 3'b011;

   localparam logic [2:0] OP_NOP  = 3'b000;
   localparam logic [2:0] OP_LDI  = 3'b001;
   localparam logic [2:0] OP_MOV  = 3'b010;
   localparam logic [2:0] OP_INC  = 3'b011;
   localparam logic [2:0] OP_DEC  = 3'b100;
   localparam logic [2:0] OP_CLR  = 3'b101;
   localparam logic [2:0] OP_SWAP = 3'b110;
   localparam logic [2:0] OP_RSVD = 3'b111;

   localparam logic [2:0] R1 = 3'd0;
   localparam logic [2:0] R2 = 3'd1;
   localparam logic [2:0] R3 = 3'd2;
   localparam logic [2:0] R4 = 3'd3;
   localparam logic [2:0] S1 = 3'd4;
   localparam logic [2:0] S2 = 3'd5;
   localparam logic [2:0] S3 = 3'd6;
   localparam logic [2:0] S4 = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EX1  = 2'd1,
      ST_EX2  = 2'd2,
      ST_EX3  = 2'd3
   } seq_state_e;

   typedef struct packed {
      logic [2:0] opcode;
      logic [2:0] dst;
      logic [2:0] src;
   } cmd_t;

endpackage

// File: rtl/regsel_decoder.sv
// Decodes a 3-bit register index plus write flag into the RegSel/ScrSel
// enable vectors (bit 3 selects R1/S1).
module regsel_decoder
   import regfile_pkg::*;
(
   input  logic [2:0] idx_i,
   input  logic       we_i,
   output logic [3:0] reg_sel_o,
   output logic [3:0] scr_sel_o
);

   logic [3:0] onehot;

   assign onehot    = 4'b1000 >> idx_i[1:0];
   assign reg_sel_o = (we_i && !idx_i[2]) ? onehot : 4'b0000;
   assign scr_sel_o = (we_i &&  idx_i[2]) ? onehot : 4'b0000;

endmodule

// File: rtl/regfile_cmd_sequencer.sv
// Turns one register-level command into the OutASel/FunSel/RegSel/ScrSel/DataSel
// sequence for the 8-entry register file. Optional CmdCount port: RFSEQ_PERF_EN.
module regfile_cmd_sequencer
   import regfile_pkg::*;
#(
   parameter int         DATA_WIDTH    = 32,
   parameter logic [2:0] SWAP_TEMP     = 3'b111,
   parameter logic [2:0] SWAP_ALT_TEMP = 3'b110
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  InstValid,
   output logic                  InstReady,
   input  logic [2:0]            Opcode,
   input  logic [2:0]            DstSel,
   input  logic [2:0]            SrcSel,
   input  logic [DATA_WIDTH-1:0] Imm,
   output logic [DATA_WIDTH-1:0] ImmOut,
   output logic                  DataSel,
   output logic [2:0]            OutASel,
   output logic [2:0]            OutBSel,
   output logic [2:0]            FunSel,
   output logic [3:0]            RegSel,
   output logic [3:0]            ScrSel,
`ifdef RFSEQ_PERF_EN
   output logic [15:0]           CmdCount,
`endif
   output logic                  Done,
   output logic                  IllegalOp
);

   seq_state_e            state_q, state_d;
   cmd_t                  cmd_q, cmd_d;
   logic [DATA_WIDTH-1:0] imm_q, imm_d;
   logic                  accept;
   logic [2:0]            swap_tmp;
   logic                  wr_en;
   logic [2:0]            wr_idx;

   assign accept   = InstValid && (state_q == ST_IDLE);
   assign swap_tmp = (cmd_q.src == SWAP_TEMP || cmd_q.dst == SWAP_TEMP) ? SWAP_ALT_TEMP : SWAP_TEMP;

   assign cmd_d = accept ? '{opcode: Opcode, dst: DstSel, src: SrcSel} : cmd_q;
   assign imm_d = accept ? Imm : imm_q;

   // NOTE: reset is sampled on the clock edge, and all state uses non-blocking
   // assignments so every register sees pre-edge values of the others.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= ST_IDLE;
         cmd_q   <= '0;
         imm_q   <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         imm_q   <= imm_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = ST_EX1;
         ST_EX1:  state_d = (cmd_q.opcode == OP_SWAP && cmd_q.src != cmd_q.dst) ? ST_EX2 : ST_IDLE;
         ST_EX2:  state_d = ST_EX3;
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      OutASel   = R1;
      FunSel    = FS_LOAD;
      DataSel   = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = cmd_q.dst;
      Done      = 1'b0;
      IllegalOp = 1'b0;
      case (state_q)
         ST_EX1: begin
            Done = 1'b1;
            case (cmd_q.opcode)
               OP_LDI: wr_en = 1'b1;
               OP_MOV: begin
                  OutASel = cmd_q.src;
                  DataSel = 1'b1;
                  wr_en   = 1'b1;
               end
               OP_INC: begin
                  FunSel = FS_INC;
                  wr_en  = 1'b1;
               end
               OP_DEC: begin
                  FunSel = FS_DEC;
                  wr_en  = 1'b1;
               end
               OP_CLR: begin
                  FunSel = FS_CLR;
                  wr_en  = 1'b1;
               end
               OP_SWAP: begin
                  if (cmd_q.src != cmd_q.dst) begin
                     Done    = 1'b0;
                     OutASel = cmd_q.dst;
                     DataSel = 1'b1;
                     wr_en   = 1'b1;
                     wr_idx  = swap_tmp;
                  end
               end
               OP_RSVD: IllegalOp = 1'b1;
               default: ;
            endcase
         end
         ST_EX2: begin
            OutASel = cmd_q.src;
            DataSel = 1'b1;
            wr_en   = 1'b1;
            wr_idx  = cmd_q.dst;
         end
         ST_EX3: begin
            OutASel = swap_tmp;
            DataSel = 1'b1;
            wr_en   = 1'b1;
            wr_idx  = cmd_q.src;
            Done    = 1'b1;
         end
         default: ;
      endcase
   end

   regsel_decoder u_regsel_decoder (
      .idx_i     (wr_idx),
      .we_i      (wr_en),
      .reg_sel_o (RegSel),
      .scr_sel_o (ScrSel)
   );

   assign InstReady = (state_q == ST_IDLE);
   assign OutBSel   = cmd_q.dst;
   assign ImmOut    = imm_q;

`ifdef RFSEQ_PERF_EN
   logic [15:0] cmd_count_q, cmd_count_d;

   assign cmd_count_d = (Done && cmd_count_q != 16'hFFFF) ? cmd_count_q + 16'd1 : cmd_count_q;

   always_ff @(posedge Clock) begin
      if (Reset) cmd_count_q <= '0;
      else       cmd_count_q <= cmd_count_d;
   end

   assign CmdCount = cmd_count_q;
`endif

endmodule

// File: tb/tb_regfile_cmd_sequencer.sv
// Self-checking bench for regfile_cmd_sequencer: scoreboard of per-cycle control
// expectations plus a register-file model driven by the DUT outputs.
module tb_regfile_cmd_sequencer;
   import regfile_pkg::*;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        InstValid;
   logic        InstReady;
   logic [2:0]  Opcode, DstSel, SrcSel;
   logic [31:0] Imm, ImmOut;
   logic        DataSel;
   logic [2:0]  OutASel, OutBSel, FunSel;
   logic [3:0]  RegSel, ScrSel;
   logic        Done, IllegalOp;
`ifdef RFSEQ_PERF_EN
   logic [15:0] CmdCount;
   logic [15:0] exp_count = '0;
`endif

   typedef struct packed {
      logic [3:0] reg_sel;
      logic [3:0] scr_sel;
      logic [2:0] fun_sel;
      logic [2:0] out_a;
      logic       data_sel;
      logic       done;
      logic       illegal;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] rf[8];
   int          tests = 0;
   int          fails = 0;

   always #5 Clock = ~Clock;

   regfile_cmd_sequencer dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .InstValid (InstValid),
      .InstReady (InstReady),
      .Opcode    (Opcode),
      .DstSel    (DstSel),
      .SrcSel    (SrcSel),
      .Imm       (Imm),
      .ImmOut    (ImmOut),
      .DataSel   (DataSel),
      .OutASel   (OutASel),
      .OutBSel   (OutBSel),
      .FunSel    (FunSel),
      .RegSel    (RegSel),
      .ScrSel    (ScrSel),
`ifdef RFSEQ_PERF_EN
      .CmdCount  (CmdCount),
`endif
      .Done      (Done),
      .IllegalOp (IllegalOp)
   );

   // Register file as the environment sees it; only LOAD writes matter here.
   always @(posedge Clock) begin
      for (int i = 0; i < 4; i++) begin
         if (RegSel[3-i] && FunSel == FS_LOAD) rf[i]   <= DataSel ? rf[OutASel] : ImmOut;
         if (ScrSel[3-i] && FunSel == FS_LOAD) rf[4+i] <= DataSel ? rf[OutASel] : ImmOut;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic we, input logic [2:0] idx, input logic [2:0] fs,
                               input logic [2:0] oa, input logic ds, input logic dn,
                               input logic ill);
      exp_t       e;
      logic [7:0] en;
      en         = we ? (8'h80 >> idx) : 8'h00;
      e.reg_sel  = en[7:4];
      e.scr_sel  = en[3:0];
      e.fun_sel  = fs;
      e.out_a    = oa;
      e.data_sel = ds;
      e.done     = dn;
      e.illegal  = ill;
      return e;
   endfunction

   task automatic push_exp(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src);
      logic [2:0] t;
      t = (src == S4 || dst == S4) ? S3 : S4;
      case (op)
         OP_LDI:  exp_q.push_back(mk(1, dst, FS_LOAD, 3'd0, 0, 1, 0));
         OP_MOV:  exp_q.push_back(mk(1, dst, FS_LOAD, src, 1, 1, 0));
         OP_INC:  exp_q.push_back(mk(1, dst, FS_INC, 3'd0, 0, 1, 0));
         OP_DEC:  exp_q.push_back(mk(1, dst, FS_DEC, 3'd0, 0, 1, 0));
         OP_CLR:  exp_q.push_back(mk(1, dst, FS_CLR, 3'd0, 0, 1, 0));
         OP_RSVD: exp_q.push_back(mk(0, dst, FS_LOAD, 3'd0, 0, 1, 1));
         OP_SWAP: begin
            if (src == dst) exp_q.push_back(mk(0, dst, FS_LOAD, 3'd0, 0, 1, 0));
            else begin
               exp_q.push_back(mk(1, t,   FS_LOAD, dst, 1, 0, 0));
               exp_q.push_back(mk(1, dst, FS_LOAD, src, 1, 0, 0));
               exp_q.push_back(mk(1, src, FS_LOAD, t,   1, 1, 0));
            end
         end
         default: exp_q.push_back(mk(0, dst, FS_LOAD, 3'd0, 0, 1, 0));
      endcase
   endtask

   task automatic check_cycle(input string tag, input exp_t e, input logic [2:0] dst,
                              input logic [31:0] imm);
      check({tag, "_regsel"},  RegSel,    e.reg_sel);
      check({tag, "_scrsel"},  ScrSel,    e.scr_sel);
      check({tag, "_funsel"},  FunSel,    e.fun_sel);
      check({tag, "_outa"},    OutASel,   e.out_a);
      check({tag, "_datasel"}, DataSel,   e.data_sel);
      check({tag, "_done"},    Done,      e.done);
      check({tag, "_illegal"}, IllegalOp, e.illegal);
      check({tag, "_ready"},   InstReady, 0);
      check({tag, "_outb"},    OutBSel,   dst);
      check({tag, "_immout"},  ImmOut,    imm);
   endtask

   task automatic run_cmd(input string tag, input logic [2:0] op, input logic [2:0] dst,
                          input logic [2:0] src, input logic [31:0] imm);
      exp_t e;
      @(negedge Clock);
      check({tag, "_ready_pre"}, InstReady, 1);
      Opcode    = op;
      DstSel    = dst;
      SrcSel    = src;
      Imm       = imm;
      InstValid = 1'b1;
      push_exp(op, dst, src);
      @(posedge Clock);
      #1;
      InstValid = 1'b0;
      Opcode    = 3'($urandom);
      DstSel    = 3'($urandom);
      SrcSel    = 3'($urandom);
      Imm       = $urandom;
      while (exp_q.size() > 0) begin
         @(negedge Clock);
         e = exp_q.pop_front();
         check_cycle(tag, e, dst, imm);
`ifdef RFSEQ_PERF_EN
         if (e.done && exp_count != 16'hFFFF) exp_count++;
`endif
      end
      @(negedge Clock);
      check({tag, "_ready_post"},  InstReady, 1);
      check({tag, "_regsel_post"}, RegSel,    0);
      check({tag, "_scrsel_post"}, ScrSel,    0);
      check({tag, "_done_post"},   Done,      0);
`ifdef RFSEQ_PERF_EN
      check({tag, "_cmdcount"}, CmdCount, exp_count);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 8; i++) rf[i] = '0;
      Reset     = 1'b1;
      InstValid = 1'b0;
      Opcode    = OP_NOP;
      DstSel    = R1;
      SrcSel    = R1;
      Imm       = '0;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      check("rst_ready",   InstReady, 1);
      check("rst_regsel",  RegSel,    0);
      check("rst_scrsel",  ScrSel,    0);
      check("rst_funsel",  FunSel,    FS_LOAD);
      check("rst_outa",    OutASel,   0);
      check("rst_outb",    OutBSel,   0);
      check("rst_datasel", DataSel,   0);
      check("rst_done",    Done,      0);
      check("rst_illegal", IllegalOp, 0);
      check("rst_immout",  ImmOut,    0);
`ifdef RFSEQ_PERF_EN
      check("rst_cmdcount", CmdCount, 0);
`endif
      Reset = 1'b0;

      run_cmd("ldi_r2", OP_LDI, R2, R1, 32'hDEADBEEF);
      check("ldi_r2_val", rf[R2], 32'hDEADBEEF);
      run_cmd("ldi_r1", OP_LDI, R1, R3, 32'd5);
      run_cmd("ldi_r4", OP_LDI, R4, R3, 32'd9);

      run_cmd("mov_s3", OP_MOV, S3, R1, 32'd0);
      check("mov_s3_val", rf[S3], 32'd5);

      run_cmd("swap_r4_r1", OP_SWAP, R4, R1, 32'd0);
      check("swap_r1_val", rf[R1], 32'd9);
      check("swap_r4_val", rf[R4], 32'd5);

      run_cmd("ldi_s4", OP_LDI, S4, R1, 32'h44);
      run_cmd("swap_s4_r2", OP_SWAP, S4, R2, 32'd0);
      check("swap_s4_val", rf[S4], 32'hDEADBEEF);
      check("swap_r2_val", rf[R2], 32'h44);

      run_cmd("swap_same", OP_SWAP, R3, R3, 32'd0);
      run_cmd("inc_s1",    OP_INC,  S1, R1, 32'd0);
      run_cmd("dec_r3",    OP_DEC,  R3, R1, 32'd0);
      run_cmd("clr_s2",    OP_CLR,  S2, R1, 32'd0);
      run_cmd("nop",       OP_NOP,  R4, R2, 32'd0);
      run_cmd("illegal",   OP_RSVD, R2, S1, 32'd0);

      // Reset asserted during EX2 of a SWAP.
      @(negedge Clock);
      Opcode    = OP_SWAP;
      DstSel    = R2;
      SrcSel    = R1;
      Imm       = 32'd0;
      InstValid = 1'b1;
      @(posedge Clock);
      #1;
      InstValid = 1'b0;
      @(negedge Clock);
      check("rswap_ex1_scrsel", ScrSel, 4'b0001);
      check("rswap_ex1_done",   Done,   0);
      @(negedge Clock);
      check("rswap_ex2_regsel", RegSel,  4'b0100);
      check("rswap_ex2_outa",   OutASel, R1);
      Reset = 1'b1;
      @(negedge Clock);
      check("rswap_rst_ready",  InstReady, 1);
      check("rswap_rst_regsel", RegSel,    0);
      check("rswap_rst_scrsel", ScrSel,    0);
      check("rswap_rst_done",   Done,      0);
`ifdef RFSEQ_PERF_EN
      exp_count = '0;
      check("rswap_rst_cmdcount", CmdCount, exp_count);
`endif
      Reset = 1'b0;

      run_cmd("post_rst_ldi", OP_LDI, S1, R1, 32'h1234_5678);
      check("post_rst_ldi_val", rf[S1], 32'h1234_5678);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
